// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional macro CLA_SATURATE_EN clamps s to the signed range on overflow.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             PP,
  output logic             GG
);

  localparam int NG = WIDTH / 4;

  generate
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH % 4) != 0) begin : g_bad_width
      $error("pipelined_cla_addsub: WIDTH must be a multiple of 4 in 4..64");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff, p_in, g_in;
  logic [NG-1:0]    gp_in, gg_in;

  always_comb begin
    b_eff = sub ? ~b : b;
    p_in  = a ^ b_eff;
    g_in  = a & b_eff;
    gp_in = '0;
    gg_in = '0;
    for (int grp = 0; grp < NG; grp++) begin
      gp_in[grp] = &p_in[4*grp +: 4];
      gg_in[grp] = g_in[4*grp+3]
                 | (p_in[4*grp+3] & g_in[4*grp+2])
                 | (p_in[4*grp+3] & p_in[4*grp+2] & g_in[4*grp+1])
                 | (p_in[4*grp+3] & p_in[4*grp+2] & p_in[4*grp+1] & g_in[4*grp]);
    end
  end

  logic [WIDTH-1:0] p1, g1;
  logic [NG-1:0]    gp1, gg1;
  logic             cin1, sa1, sb1, v1;
  logic             load2, in_fire;

  assign load2    = !out_valid || out_ready;
  assign in_ready = !rst && (!v1 || load2);
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      p1   <= p_in;
      g1   <= g_in;
      gp1  <= gp_in;
      gg1  <= gg_in;
      cin1 <= sub | c_in;
      sa1  <= a[WIDTH-1];
      sb1  <= b_eff[WIDTH-1];
    end
  end

  // Group carries are flat sum-of-products over all lower groups, so no
  // carry ripples from one group to the next.
  logic [NG:0]      gc;
  logic [WIDTH-1:0] c_bit;
  logic             word_gg;

  always_comb begin : cla_carries
    logic acc, run, c;
    gc      = '0;
    c_bit   = '0;
    word_gg = 1'b0;
    acc     = 1'b0;
    run     = 1'b0;
    c       = 1'b0;
    gc[0]   = cin1;
    for (int grp = 0; grp < NG; grp++) begin
      acc = gg1[grp];
      run = gp1[grp];
      for (int j = grp - 1; j >= 0; j--) begin
        acc = acc | (gg1[j] & run);
        run = run & gp1[j];
      end
      gc[grp+1] = acc | (run & cin1);
      if (grp == NG - 1) word_gg = acc;
    end
    for (int grp = 0; grp < NG; grp++) begin
      c = gc[grp];
      for (int k = 0; k < 4; k++) begin
        c_bit[4*grp+k] = c;
        c = g1[4*grp+k] | (p1[4*grp+k] & c);
      end
    end
  end

  logic [WIDTH-1:0] sum, s_nxt;
  logic             ovf_nxt;

  always_comb begin
    sum     = p1 ^ c_bit;
    ovf_nxt = (sa1 == sb1) && (sum[WIDTH-1] != sa1);
    s_nxt   = sum;
`ifdef CLA_SATURATE_EN
    if (ovf_nxt) s_nxt = sa1 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    s_nxt   = sum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      PP        <= 1'b0;
      GG        <= 1'b0;
    end else if (load2) begin
      out_valid <= v1;
      if (v1) begin
        s     <= s_nxt;
        c_out <= gc[NG];
        ovf   <= ovf_nxt;
        PP    <= &p1;
        GG    <= word_gg;
      end
    end
  end

endmodule
